// File: rtl/spike_synapse_if.sv
// Spike-synapse bus: spike input, weight and decay control from the source side,
// synaptic current, refractory flag and debug counters back from the synapse.
interface spike_synapse_if;
    logic       spike_in;
    logic [7:0] weight;
    logic [2:0] decay_shift;
    logic [7:0] i_syn;
    logic       refrac;
    logic [7:0] dropped;
    logic [7:0] rate_out;
    logic       rate_valid;

    modport master (
        output spike_in, weight, decay_shift,
        input  i_syn, refrac, dropped, rate_out, rate_valid
    );

    modport slave (
        input  spike_in, weight, decay_shift,
        output i_syn, refrac, dropped, rate_out, rate_valid
    );
endinterface

// File: rtl/spike_synapse.sv
// Spike synapse: turns spike_in rising edges into an 8-bit decaying, saturating synaptic
// current, enforces a refractory lockout after each accepted spike, counts rejected
// spikes and reports the accepted-spike rate over a fixed window.
module spike_synapse #(
    parameter int DECAY_DIV = 16,   // cycles between decay ticks (>=1)
    parameter int REFRAC    = 4,    // lockout cycles after an accepted spike
    parameter int WINDOW    = 1000  // rate window length in cycles (>=2)
) (
    input logic            clk,
    input logic            reset,
    spike_synapse_if.slave bus
);

    localparam int PW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam int RW = (REFRAC > 1) ? $clog2(REFRAC) : 1;
    localparam int WW = $clog2(WINDOW);

    localparam logic [PW-1:0] PRE_LAST  = PW'(DECAY_DIV - 1);
    localparam logic [RW-1:0] RCNT_LOAD = (REFRAC > 0) ? RW'(REFRAC - 1) : '0;
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);

    typedef enum logic {
        READY      = 1'b0,
        REFRACTORY = 1'b1
    } state_t;

    state_t          state, next_state;
    logic            spike_d;
    logic            ev;
    logic [PW-1:0]   pcnt;
    logic            tick;
    logic [RW-1:0]   rcnt, rcnt_next;
    logic            accept;
    logic            reject;
    logic [7:0]      acc, acc_next;
    logic [7:0]      dec;
    logic signed [9:0] sum;
    logic [7:0]      dropped;
    logic [WW-1:0]   wcnt;
    logic [7:0]      scnt, scnt_inc;
    logic [7:0]      rate_out;
    logic            rate_valid;

    assign ev   = bus.spike_in & ~spike_d;
    assign tick = (pcnt == PRE_LAST);

    // Delay the spike line by one cycle for rising-edge detection.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) spike_d <= 1'b0;
        else       spike_d <= bus.spike_in;
    end

    // Decay prescaler: free-running 0..DECAY_DIV-1, tick on the last count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     pcnt <= '0;
        else if (tick) pcnt <= '0;
        else           pcnt <= pcnt + PW'(1);
    end

    // FSM state and refractory counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= READY;
            rcnt  <= '0;
        end else begin
            state <= next_state;
            rcnt  <= rcnt_next;
        end
    end

    // FSM next state: accept edges in READY, reject them while locked out.
    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        rcnt_next  = rcnt;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            READY: begin
                if (ev) begin
                    accept = 1'b1;
                    if (REFRAC > 0) begin
                        next_state = REFRACTORY;
                        rcnt_next  = RCNT_LOAD;
                    end
                end
            end
            REFRACTORY: begin
                reject = ev;
                if (rcnt == '0) next_state = READY;
                else            rcnt_next  = rcnt - RW'(1);
            end
            default: next_state = READY;
        endcase
    end

    // Accumulator update: decay first, then add the weight, clamp to 0..255.
    always_comb begin
        dec = '0;
        if (tick && (bus.decay_shift != 3'd0)) dec = acc >> bus.decay_shift;
        sum = $signed({2'b00, acc}) - $signed({2'b00, dec});
        if (accept) sum = sum + $signed({{2{bus.weight[7]}}, bus.weight});
        if (sum < 10'sd0)        acc_next = 8'd0;
        else if (sum > 10'sd255) acc_next = 8'hFF;
        else                     acc_next = sum[7:0];
    end

    // Accumulator register drives i_syn directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc <= 8'd0;
        else       acc <= acc_next;
    end

    // Saturating count of spikes rejected during refractory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         dropped <= 8'd0;
        else if (reject && dropped != 8'hFF) dropped <= dropped + 8'd1;
    end

    // Spike count including the current cycle's accepted edge, saturating.
    always_comb begin
        scnt_inc = scnt;
        if (accept && scnt != 8'hFF) scnt_inc = scnt + 8'd1;
    end

    // Rate window: publish the count at the last window cycle and restart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt       <= '0;
            scnt       <= 8'd0;
            rate_out   <= 8'd0;
            rate_valid <= 1'b0;
        end else if (wcnt == WIN_LAST) begin
            wcnt       <= '0;
            scnt       <= 8'd0;
            rate_out   <= scnt_inc;
            rate_valid <= 1'b1;
        end else begin
            wcnt       <= wcnt + WW'(1);
            scnt       <= scnt_inc;
            rate_valid <= 1'b0;
        end
    end

    assign bus.i_syn      = acc;
    assign bus.refrac     = (state == REFRACTORY);
    assign bus.dropped    = dropped;
    assign bus.rate_out   = rate_out;
    assign bus.rate_valid = rate_valid;

endmodule
